// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: latches the EX branch target, drives the fetch mux and flushes IF/ID and ID/EX.
// Redirect is visible 1 cycle after accept; cache stalls defer entry and freeze the flush. Perf counters: BR_REDIRECT_PERF_EN.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ex_valid_i,
  input  logic            ex_br_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            stall_i,
  output logic            pc_sel_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic            busy_o,
  output logic [31:0]     br_taken_cnt_o,
  output logic [31:0]     stall_wait_cnt_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_cfg
    $error("branch_redirect_ctrl: FLUSH_CYCLES must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(FLUSH_CYCLES - 1);

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic            pc_sel_q;
  logic [XLEN-1:0] pc_target_q;
  logic            flush_q;
  logic            busy_q;
  logic            accept;

  assign accept = ex_valid_i & ex_br_taken_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pc_target_q <= ex_target_i;
            busy_q      <= 1'b1;
            if (!stall_i) begin
              state_q  <= FLUSH;
              cnt_q    <= 2'd0;
              pc_sel_q <= 1'b1;
              flush_q  <= 1'b1;
            end else begin
              state_q  <= PENDING;
            end
          end
        end
        PENDING: begin
          if (!stall_i) begin
            state_q  <= FLUSH;
            cnt_q    <= 2'd0;
            pc_sel_q <= 1'b1;
            flush_q  <= 1'b1;
          end
        end
        FLUSH: begin
          // A stall freezes the count and every output in place.
          if (!stall_i) begin
            if (cnt_q == LAST_CNT) begin
              state_q  <= IDLE;
              pc_sel_q <= 1'b0;
              flush_q  <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              cnt_q    <= cnt_q + 2'd1;
              pc_sel_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          pc_sel_q <= 1'b0;
          flush_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_sel_o     = pc_sel_q;
  assign pc_target_o  = pc_target_q;
  assign flush_ifid_o = flush_q;
  assign flush_idex_o = flush_q;
  assign busy_o       = busy_q;

`ifdef BR_REDIRECT_PERF_EN
  logic        enter_flush;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  assign enter_flush = ((state_q == IDLE) & accept & !stall_i) |
                       ((state_q == PENDING) & !stall_i);

  always_comb begin
    br_cnt_d   = br_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (enter_flush && br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
    if (state_q == PENDING && wait_cnt_q != 32'hFFFF_FFFF) wait_cnt_d = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      br_cnt_q   <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign br_taken_cnt_o   = br_cnt_q;
  assign stall_wait_cnt_o = wait_cnt_q;
`else
  assign br_taken_cnt_o   = 32'd0;
  assign stall_wait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench: three instances (FLUSH_CYCLES 1, 3, 4) share one stimulus stream.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_br_taken;
  logic [31:0] ex_target;
  logic        stall;

  logic        pc_sel1, fi1, fd1, busy1;
  logic [31:0] tgt1, brc1, wtc1;
  logic        pc_sel3, fi3, fd3, busy3;
  logic [31:0] tgt3, brc3, wtc3;
  logic        pc_sel4, fi4, fd4, busy4;
  logic [31:0] tgt4, brc4, wtc4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_br_taken_i(ex_br_taken),
    .ex_target_i(ex_target), .stall_i(stall), .pc_sel_o(pc_sel1), .pc_target_o(tgt1),
    .flush_ifid_o(fi1), .flush_idex_o(fd1), .busy_o(busy1),
    .br_taken_cnt_o(brc1), .stall_wait_cnt_o(wtc1));

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_br_taken_i(ex_br_taken),
    .ex_target_i(ex_target), .stall_i(stall), .pc_sel_o(pc_sel3), .pc_target_o(tgt3),
    .flush_ifid_o(fi3), .flush_idex_o(fd3), .busy_o(busy3),
    .br_taken_cnt_o(brc3), .stall_wait_cnt_o(wtc3));

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .ex_valid_i(ex_valid), .ex_br_taken_i(ex_br_taken),
    .ex_target_i(ex_target), .stall_i(stall), .pc_sel_o(pc_sel4), .pc_target_o(tgt4),
    .flush_ifid_o(fi4), .flush_idex_o(fd4), .busy_o(busy4),
    .br_taken_cnt_o(brc4), .stall_wait_cnt_o(wtc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] t, input logic s);
    ex_valid    = v;
    ex_br_taken = v;
    ex_target   = t;
    stall       = s;
  endtask

  int flush_hi;
  int sel_hi;

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h0000_0040, 1'b0);

    // 1: reset dominates a live accept
    tick(); tick();
    chk("rst_pc_sel", {31'd0, pc_sel1}, 32'd0);
    chk("rst_target", tgt1, 32'd0);
    chk("rst_flush", {30'd0, fi1, fd1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_brcnt", brc1, 32'd0);
    drive(1'b0, 32'h0000_0040, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {30'd0, pc_sel1, busy1}, 32'd0);

    // 2: single-cycle redirect, FLUSH_CYCLES=1
    drive(1'b1, 32'h0000_0040, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("t2_pc_sel", {31'd0, pc_sel1}, 32'd1);
    chk("t2_target", tgt1, 32'h0000_0040);
    chk("t2_flush", {30'd0, fi1, fd1}, 32'd3);
    chk("t2_busy", {31'd0, busy1}, 32'd1);
    tick();
    chk("t2_drop", {29'd0, pc_sel1, fi1, busy1}, 32'd0);
    chk("t2_hold_tgt", tgt1, 32'h0000_0040);
`ifdef BR_REDIRECT_PERF_EN
    chk("t2_brcnt", brc1, 32'd1);
`else
    chk("t2_brcnt_off", brc1, 32'd0);
`endif
    repeat (5) tick();

    // 3: accept under stall waits in PENDING for 3 cycles
    drive(1'b1, 32'h0000_0080, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("t3_pend0", {30'd0, pc_sel1, busy1}, 32'd1);
    tick();
    chk("t3_pend1", {30'd0, pc_sel1, busy1}, 32'd1);
    tick();
    chk("t3_pend2", {29'd0, pc_sel1, fi1, busy1}, 32'd1);
    stall = 1'b0;
    tick();
    chk("t3_pc_sel", {31'd0, pc_sel1}, 32'd1);
    chk("t3_target", tgt1, 32'h0000_0080);
`ifdef BR_REDIRECT_PERF_EN
    chk("t3_waitcnt", wtc1, 32'd3);
    chk("t3_brcnt", brc1, 32'd2);
`else
    chk("t3_waitcnt_off", wtc1, 32'd0);
`endif
    tick();
    chk("t3_done", {31'd0, busy1}, 32'd0);
    repeat (5) tick();

    // 4: FLUSH_CYCLES=3 with a 2-cycle stall in the 2nd flush cycle
    flush_hi = 0;
    sel_hi   = 0;
    drive(1'b1, 32'h0000_00C0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      ex_valid    = 1'b0;
      ex_br_taken = 1'b0;
      stall       = (i == 1 || i == 2);
      if (fi3 && fd3) flush_hi = flush_hi + 1;
      if (pc_sel3) sel_hi = sel_hi + 1;
      if (i == 0) chk("t4_sel_first", {31'd0, pc_sel3}, 32'd1);
    end
    chk("t4_flush_cycles", flush_hi, 32'd5);
    chk("t4_sel_cycles", sel_hi, 32'd1);
    chk("t4_idle", {31'd0, busy3}, 32'd0);
    repeat (3) tick();

    // 5: wrong-path accept ignored during FLUSH, taken on return to IDLE
    drive(1'b1, 32'h0000_0100, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0200, 1'b0);
    chk("t5_first", tgt3, 32'h0000_0100);
    tick();
    chk("t5_ignored_a", tgt3, 32'h0000_0100);
    tick();
    chk("t5_ignored_b", tgt3, 32'h0000_0100);
    tick();
    chk("t5_back_idle", {31'd0, busy3}, 32'd0);
    chk("t5_tgt_hold", tgt3, 32'h0000_0100);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("t5_redir_sel", {31'd0, pc_sel3}, 32'd1);
    chk("t5_redir_tgt", tgt3, 32'h0000_0200);
    repeat (6) tick();

    // 6: asynchronous reset in the 2nd of 4 flush cycles
    drive(1'b1, 32'h0000_0300, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("t6_mid_flush", {29'd0, pc_sel4, fi4, busy4}, 32'd3);
    reset = 1'b1;
    #2;
    chk("t6_async_out", {28'd0, pc_sel4, fi4, fd4, busy4}, 32'd0);
    chk("t6_async_tgt", tgt4, 32'd0);
    tick();
    reset = 1'b0;
    sel_hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pc_sel4 || busy4) sel_hi = sel_hi + 1;
    end
    chk("t6_no_resume", sel_hi, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
